// File: rtl/apb_master_bridge.sv
// Single-outstanding APB4 master: valid/ready command in, one-cycle response out.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that never see PREADY.
module apb_master_bridge #(
    parameter int ADDWIDTH  = 8,
    parameter int DATAWIDTH = 32,
    parameter int NSLAVES   = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                                     PCLK,
    input  logic                                     PRESETn,
    input  logic                                     cmd_valid,
    output logic                                     cmd_ready,
    input  logic                                     cmd_write,
    input  logic [$clog2(NSLAVES)+ADDWIDTH-1:0]      cmd_addr,
    input  logic [DATAWIDTH-1:0]                     cmd_wdata,
    input  logic [DATAWIDTH/8-1:0]                   cmd_strb,
    output logic                                     rsp_valid,
    output logic [DATAWIDTH-1:0]                     rsp_rdata,
    output logic                                     rsp_err,
    output logic [NSLAVES-1:0]                       PSEL,
    output logic                                     PENABLE,
    output logic                                     PWRITE,
    output logic [ADDWIDTH-1:0]                      PADDR,
    output logic [DATAWIDTH-1:0]                     PWDATA,
    output logic [DATAWIDTH/8-1:0]                   PSTRB,
    input  logic [NSLAVES-1:0]                       PREADY,
    input  logic [NSLAVES*DATAWIDTH-1:0]             PRDATA
);
    localparam int SELW = $clog2(NSLAVES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                 state;
    logic [SELW-1:0]        sel_q;
    logic [SELW-1:0]        cmd_sel;
    logic                   sel_ok;
    logic [NSLAVES-1:0]     onehot;
    logic                   rdy;
    logic [DATAWIDTH-1:0]   rdata;

    assign cmd_sel = cmd_addr[SELW+ADDWIDTH-1 -: SELW];
    assign sel_ok  = 32'(cmd_sel) < 32'(NSLAVES);

    // Only the latched slave's ready/data are ever looked at.
    always_comb begin
        onehot = '0;
        rdy    = 1'b0;
        rdata  = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            onehot[i] = (cmd_sel == SELW'(i));
            if (sel_q == SELW'(i)) begin
                rdy   = PREADY[i];
                rdata = PRDATA[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT+1);
    logic [CW-1:0] cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            sel_q     <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        if (sel_ok) begin
                            state     <= SETUP;
                            cmd_ready <= 1'b0;
                            sel_q     <= cmd_sel;
                            PSEL      <= onehot;
                            PWRITE    <= cmd_write;
                            PADDR     <= cmd_addr[ADDWIDTH-1:0];
                            PWDATA    <= cmd_wdata;
                            PSTRB     <= cmd_write ? cmd_strb : '0;
                        end else begin
                            // Unmapped slave: answer immediately, no bus cycle.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                    cnt     <= '0;
`endif
                end
                ACCESS: begin
                    if (rdy) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= PWRITE ? '0 : rdata;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT-1)) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
